irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller in front of the CP0 block of the pipelined MIPS core.
- Collects NSRC external interrupt lines, edge-detects and latches them, applies a software mask, and arbitrates one winner.
- Drives a single level request into the CP0 external interrupt input; tracks the CP0 take/return handshake (ir pulse, ERET) so only one source is in service at a time.
- Configured by the core through a small register port mapped off CP0 store/read traffic.

Parameters:
NSRC, 8, number of interrupt sources (2..32)
IDW, 3, cause-id width; must equal clog2(NSRC)

Ports:
clk  in  1  main clock
rst  in  1  reset, synchronous, active-high
src  in  NSRC  raw interrupt lines, synchronous to clk
cfg_we  in  1  config write strobe
cfg_addr  in  2  config register select
cfg_wdata  in  32  config write data
cfg_rdata  out  32  config read data, combinational from cfg_addr
irq_out  out  1  level request to CP0 ir_in (registered)
ack  in  1  CP0 interrupt-taken pulse (CP0 ir)
eret  in  1  CP0 ERET executed
cause_id  out  IDW  index of source requested/in service (registered)
busy  out  1  high in SERVICE state

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, mask=0, pending=0, src_prev=0, irq_out=0, cause_id=0, busy=0. Reset mid-service discards in-service and pending state.
- Edge detect: edge[i] = src[i] & ~src_prev[i]; src_prev <= src every cycle.
- pending[i] is set at the edge where edge[i]=1. Set has priority over every clear in the same cycle.
- Eligible = pending & mask[NSRC-1:0]. Winner is the lowest eligible index (fixed priority).
- Config map:
  - 0 MASK: RW; bits above NSRC read 0.
  - 1 PENDING: read; write-1-to-clear.
  - 2 STATUS: read-only {busy at bit 31, state at [9:8], cause_id at [IDW-1:0]}.
  - 3: reads 0, writes ignored.
- States: IDLE=0, REQ=1, SERVICE=2.
- IDLE:
  - if eligible != 0: go to REQ, latch cause_id=winner, irq_out<=1.
  - ack and eret are ignored.
- REQ:
  - irq_out held at 1; cause_id frozen.
  - On ack: go to SERVICE, irq_out<=0, busy<=1, clear pending[cause_id] (unless a new edge on it that cycle).
  - If the winner becomes ineligible before ack (masked or W1C): go to IDLE, irq_out<=0.
  - eret is ignored.
- SERVICE:
  - On eret: go to IDLE, busy<=0. A new arbitration starts the next cycle.
  - ack is ignored. New edges keep latching into pending.
- Simultaneous ack and eret in REQ: ack wins.
- Latency: src rises, sampled at edge t; pending=1 after t; irq_out=1 after edge t+1. irq_out drops in the cycle after ack.
- Back-to-back: after eret, irq_out re-asserts at earliest 2 edges later. This guarantees a 0 gap, so the CP0 edge detector sees a fresh rising edge.

Optional Feature:
- Macro: IRQ_CTRL_RR_EN.
- Defined: round-robin arbitration. A rotating pointer holds last_grant+1 mod NSRC and is updated on ack. The winner is the first eligible index at or after the pointer. Pointer resets to 0.
- Undefined: fixed lowest-index priority; no pointer register.

Decomposition:
- Shared package/header (mips_define.vh style): state encodings IRQ_IDLE/IRQ_REQ/IRQ_SERVICE and config address constants IRQ_CFG_MASK/PEND/STAT.
- One sub-module, irq_prio_enc: combinational eligible-vector + start-pointer to {valid, index}. It is a fixed encoder when the pointer is tied to 0.

Test Plan:
- Reset, MASK=0xFF, pulse src[3] for 1 cycle -> pending=0x08 after 1 edge; irq_out=1, cause_id=3 after 2 edges; ack -> irq_out=0, busy=1, pending=0; eret -> busy=0, state IDLE.
- MASK=0xFF, src[5] and src[2] rise together -> cause_id=2 first. After ack+eret -> cause_id=5. With IRQ_CTRL_RR_EN, after granting 5 then raising 2 and 6 together -> 6 wins.
- MASK=0x00, pulse src[1] -> pending=0x02, irq_out stays 0. Write MASK=0x02 -> irq_out=1 two edges later.
- In REQ for src[4], write PENDING=0x10 (W1C) -> IDLE, irq_out=0 next cycle. Same-cycle new src[4] edge keeps pending[4]=1.
- In SERVICE, src[0] rises, then eret -> irq_out=0 for at least 1 cycle, then 1 with cause_id=0. Assert rst during SERVICE -> all outputs 0, pending=0, mask=0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - state encodings, config addresses and index helper for irq_ctrl
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_SERVICE = 2'd2
   } irq_state_e;

   localparam logic [1:0] IRQ_CFG_MASK = 2'd0;
   localparam logic [1:0] IRQ_CFG_PEND = 2'd1;
   localparam logic [1:0] IRQ_CFG_STAT = 2'd2;

   // Index reached by stepping off positions forward from start, wrapping at n.
   function automatic int rr_idx(input int start, input int off, input int n);
      int j;
      j = start + off;
      if (j >= n) j = j - n;
      return j;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - first set bit of eligible at or after start; fixed priority when start is 0
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = 8,
   parameter int IDW  = 3
) (
   input  logic [NSRC-1:0] eligible,
   input  logic [IDW-1:0]  start,
   output logic            valid,
   output logic [IDW-1:0]  index
);

   logic [IDW-1:0] k;

   always_comb begin
      valid = 1'b0;
      index = '0;
      k     = '0;
      for (int i = 0; i < NSRC; i++) begin
         k = IDW'(rr_idx(int'(start), i, NSRC));
         if (!valid && eligible[k]) begin
            valid = 1'b1;
            index = k;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-latched, masked interrupt controller feeding CP0; IRQ_CTRL_RR_EN selects round-robin
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = 8,
   parameter int IDW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [31:0]     cfg_wdata,
   output logic [31:0]     cfg_rdata,
   output logic            irq_out,
   input  logic            ack,
   input  logic            eret,
   output logic [IDW-1:0]  cause_id,
   output logic            busy
);

   localparam logic [31:0] SRC_BITS = (NSRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NSRC) - 32'd1);

   irq_state_e      state_q, state_d;
   logic [31:0]     mask_q, mask_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] src_prev_q;
   logic [NSRC-1:0] edge_v, eligible, clr;
   logic            irq_out_q, irq_out_d;
   logic [IDW-1:0]  cause_id_q, cause_id_d;
   logic [IDW-1:0]  start, win_idx;
   logic            win_valid;

   assign edge_v   = src & ~src_prev_q;
   assign eligible = pending_q & mask_q[NSRC-1:0];

`ifdef IRQ_CTRL_RR_EN
   logic [IDW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == IRQ_REQ && ack)
         ptr_d = (cause_id_q == IDW'(NSRC - 1)) ? '0 : cause_id_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign start = ptr_q;
`else
   assign start = '0;
`endif

   irq_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio (
      .eligible (eligible),
      .start    (start),
      .valid    (win_valid),
      .index    (win_idx)
   );

   always_comb begin
      state_d    = state_q;
      irq_out_d  = irq_out_q;
      cause_id_d = cause_id_q;
      mask_d     = mask_q;
      clr        = '0;
      if (cfg_we && cfg_addr == IRQ_CFG_MASK) mask_d = cfg_wdata & SRC_BITS;
      if (cfg_we && cfg_addr == IRQ_CFG_PEND) clr = cfg_wdata[NSRC-1:0];
      case (state_q)
         IRQ_IDLE: begin
            if (win_valid) begin
               state_d    = IRQ_REQ;
               irq_out_d  = 1'b1;
               cause_id_d = win_idx;
            end
         end
         IRQ_REQ: begin
            // ack is checked first so a simultaneous eret cannot skip service
            if (ack) begin
               state_d         = IRQ_SERVICE;
               irq_out_d       = 1'b0;
               clr[cause_id_q] = 1'b1;
            end else if (!eligible[cause_id_q]) begin
               state_d   = IRQ_IDLE;
               irq_out_d = 1'b0;
            end
         end
         IRQ_SERVICE: begin
            if (eret) state_d = IRQ_IDLE;
         end
         default: begin
            state_d   = IRQ_IDLE;
            irq_out_d = 1'b0;
         end
      endcase
      pending_d = (pending_q & ~clr) | edge_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IRQ_IDLE;
         mask_q     <= '0;
         pending_q  <= '0;
         src_prev_q <= '0;
         irq_out_q  <= 1'b0;
         cause_id_q <= '0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         pending_q  <= pending_d;
         src_prev_q <= src;
         irq_out_q  <= irq_out_d;
         cause_id_q <= cause_id_d;
      end
   end

   assign irq_out  = irq_out_q;
   assign cause_id = cause_id_q;
   assign busy     = (state_q == IRQ_SERVICE);

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         IRQ_CFG_MASK: cfg_rdata = mask_q;
         IRQ_CFG_PEND: cfg_rdata[NSRC-1:0] = pending_q;
         IRQ_CFG_STAT: begin
            cfg_rdata[31]       = busy;
            cfg_rdata[9:8]      = state_q;
            cfg_rdata[IDW-1:0]  = cause_id_q;
         end
         default: cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  src;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        irq_out;
   logic        ack;
   logic        eret;
   logic [2:0]  cause_id;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] rd;

   irq_ctrl #(.NSRC(8), .IDW(3)) dut (
      .clk(clk), .rst(rst), .src(src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq_out(irq_out),
      .ack(ack), .eret(eret), .cause_id(cause_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic rdreg(input logic [1:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic pulse_ack();
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic pulse_eret();
      eret = 1'b1; tick(); eret = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      n_total++; if (irq_out !== 1'b0) $display("FAIL reset_irq got %0b want 0", irq_out); else n_pass++;
      n_total++; if (cause_id !== 3'd0) $display("FAIL reset_cause got %0d want 0", cause_id); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
      rdreg(2'd0, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL reset_mask got %h want 0", rd); else n_pass++;
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL reset_pend got %h want 0", rd); else n_pass++;
      rdreg(2'd2, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL reset_stat got %h want 0", rd); else n_pass++;
   endtask

   task automatic test_basic();
      wr(2'd0, 32'hFF);
      src = 8'h08; tick(); src = 8'h00;
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h08) $display("FAIL basic_pend got %h want 08", rd); else n_pass++;
      n_total++; if (irq_out !== 1'b0) $display("FAIL basic_irq_early got %0b want 0", irq_out); else n_pass++;
      tick();
      n_total++; if (irq_out !== 1'b1 || cause_id !== 3'd3) $display("FAIL basic_req got irq=%0b id=%0d want 1/3", irq_out, cause_id); else n_pass++;
      pulse_ack();
      rdreg(2'd2, rd);
      n_total++; if (irq_out !== 1'b0 || busy !== 1'b1) $display("FAIL basic_ack got irq=%0b busy=%0b want 0/1", irq_out, busy); else n_pass++;
      n_total++; if (rd !== 32'h8000_0203) $display("FAIL basic_stat_svc got %h want 80000203", rd); else n_pass++;
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL basic_pend_clr got %h want 0", rd); else n_pass++;
      pulse_eret();
      rdreg(2'd2, rd);
      n_total++; if (busy !== 1'b0 || rd !== 32'h0000_0003) $display("FAIL basic_eret got busy=%0b stat=%h want 0/00000003", busy, rd); else n_pass++;
   endtask

   task automatic test_priority();
      src = 8'h24; tick(); tick();
      n_total++; if (irq_out !== 1'b1 || cause_id !== 3'd2) $display("FAIL prio_first got irq=%0b id=%0d want 1/2", irq_out, cause_id); else n_pass++;
      pulse_eret();
      n_total++; if (irq_out !== 1'b1 || busy !== 1'b0) $display("FAIL prio_eret_in_req got irq=%0b busy=%0b want 1/0", irq_out, busy); else n_pass++;
      pulse_ack();
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h20) $display("FAIL prio_level_no_retrig got %h want 20", rd); else n_pass++;
      src = 8'h00;
      pulse_eret();
      n_total++; if (irq_out !== 1'b0) $display("FAIL prio_gap got %0b want 0", irq_out); else n_pass++;
      tick();
      n_total++; if (irq_out !== 1'b1 || cause_id !== 3'd5) $display("FAIL prio_second got irq=%0b id=%0d want 1/5", irq_out, cause_id); else n_pass++;
      pulse_ack(); pulse_eret();
      ack = 1'b1; tick(); ack = 1'b0;
      rdreg(2'd2, rd);
      n_total++; if (rd[9:8] !== 2'd0 || busy !== 1'b0) $display("FAIL idle_ack_ignored got st=%0d busy=%0b want 0/0", rd[9:8], busy); else n_pass++;
   endtask

   task automatic test_mask();
      wr(2'd0, 32'h0);
      src = 8'h02; tick(); src = 8'h00; tick(); tick();
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h02 || irq_out !== 1'b0) $display("FAIL mask_block got pend=%h irq=%0b want 02/0", rd, irq_out); else n_pass++;
      wr(2'd0, 32'h02);
      n_total++; if (irq_out !== 1'b0) $display("FAIL mask_one_edge got %0b want 0", irq_out); else n_pass++;
      tick();
      n_total++; if (irq_out !== 1'b1 || cause_id !== 3'd1) $display("FAIL mask_open got irq=%0b id=%0d want 1/1", irq_out, cause_id); else n_pass++;
      pulse_ack(); pulse_eret();
      wr(2'd0, 32'hFFFF_FFFF);
      rdreg(2'd0, rd);
      n_total++; if (rd !== 32'hFF) $display("FAIL mask_upper_bits got %h want 000000ff", rd); else n_pass++;
      wr(2'd3, 32'h0);
      rdreg(2'd0, rd);
      n_total++; if (rd !== 32'hFF) $display("FAIL addr3_write_ignored got %h want 000000ff", rd); else n_pass++;
      rdreg(2'd3, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL addr3_read got %h want 0", rd); else n_pass++;
   endtask

   task automatic test_w1c();
      src = 8'h10; tick(); src = 8'h00; tick();
      n_total++; if (irq_out !== 1'b1 || cause_id !== 3'd4) $display("FAIL w1c_req got irq=%0b id=%0d want 1/4", irq_out, cause_id); else n_pass++;
      wr(2'd1, 32'h10);
      tick();
      rdreg(2'd2, rd);
      n_total++; if (irq_out !== 1'b0 || rd[9:8] !== 2'd0) $display("FAIL w1c_drop got irq=%0b st=%0d want 0/0", irq_out, rd[9:8]); else n_pass++;
      src = 8'h10; tick(); src = 8'h00; tick();
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'h10; src = 8'h10;
      tick();
      cfg_we = 1'b0; cfg_wdata = '0; src = 8'h00;
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h10) $display("FAIL w1c_set_wins got %h want 10", rd); else n_pass++;
      tick();
      n_total++; if (irq_out !== 1'b1 || cause_id !== 3'd4) $display("FAIL w1c_stay_req got irq=%0b id=%0d want 1/4", irq_out, cause_id); else n_pass++;
      ack = 1'b1; eret = 1'b1; tick(); ack = 1'b0; eret = 1'b0;
      n_total++; if (busy !== 1'b1 || irq_out !== 1'b0) $display("FAIL ack_eret_ack_wins got busy=%0b irq=%0b want 1/0", busy, irq_out); else n_pass++;
      pulse_eret();
   endtask

   task automatic test_back_to_back();
      src = 8'h40; tick(); src = 8'h00; tick(); pulse_ack();
      src = 8'h01; tick(); src = 8'h00;
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h01 || irq_out !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_latch_svc got pend=%h irq=%0b busy=%0b want 01/0/1", rd, irq_out, busy); else n_pass++;
      pulse_eret();
      n_total++; if (irq_out !== 1'b0) $display("FAIL b2b_gap got %0b want 0", irq_out); else n_pass++;
      tick();
      n_total++; if (irq_out !== 1'b1 || cause_id !== 3'd0) $display("FAIL b2b_rearm got irq=%0b id=%0d want 1/0", irq_out, cause_id); else n_pass++;
      pulse_ack();
      src = 8'h04; tick(); src = 8'h00;
      n_total++; if (busy !== 1'b1) $display("FAIL b2b_svc got %0b want 1", busy); else n_pass++;
   endtask

   task automatic test_reset_mid_service();
      rst = 1'b1; tick(); rst = 1'b0;
      n_total++; if (irq_out !== 1'b0 || busy !== 1'b0 || cause_id !== 3'd0) $display("FAIL rst_svc_outs got irq=%0b busy=%0b id=%0d want 0/0/0", irq_out, busy, cause_id); else n_pass++;
      rdreg(2'd1, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL rst_svc_pend got %h want 0", rd); else n_pass++;
      rdreg(2'd0, rd);
      n_total++; if (rd !== 32'h0) $display("FAIL rst_svc_mask got %h want 0", rd); else n_pass++;
      tick();
      n_total++; if (irq_out !== 1'b0) $display("FAIL rst_svc_quiet got %0b want 0", irq_out); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ack = 1'b0; eret = 1'b0;
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_w1c();
      test_back_to_back();
      test_reset_mid_service();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
